leb128_decoder: RTL and testbench

LEB128_DECODER -- requirements
Module: leb128_decoder

---
 rtl/leb128_decoder_pkg.sv | 29 ++
 rtl/leb128_decoder.sv | 141 ++++++++++++++
 tb/tb_leb128_decoder.sv | 192 +++++++++++++++++++
 3 files changed

// File: rtl/leb128_decoder_pkg.sv
// Shared types for the LEB128 immediate decoder: FSM states, byte limits
// and the cpu value-type definitions the decoder tags its operands with.
package leb128_decoder_pkg;

   localparam int unsigned MAX_BYTES_I32 = 5;
   localparam int unsigned MAX_BYTES_I64 = 10;
   localparam int unsigned VALUE_W       = 64;
   localparam int unsigned LEN_W         = 4;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_ACCUM = 2'd1,
      ST_DONE  = 2'd2,
      ST_ERROR = 2'd3
   } state_e;

   typedef enum logic [1:0] {
      VT_I32 = 2'd0,
      VT_I64 = 2'd1,
      VT_F32 = 2'd2,
      VT_F64 = 2'd3
   } val_type_e;

   typedef struct packed {
      logic      is_signed;
      val_type_e vtype;
   } mode_t;

endpackage

// File: rtl/leb128_decoder.sv
// Byte-serial ULEB128/SLEB128 decoder for i32/i64 immediates, one byte per
// cycle, with length-limit checking and result held until consumed.
module leb128_decoder
   import leb128_decoder_pkg::*;
(
   input  logic               clk,
   input  logic               reset,
   input  logic               start,
   input  logic               is_signed,
   input  logic               width64,
   input  logic [7:0]         in_data,
   input  logic               in_valid,
   output logic               in_ready,
   output logic [VALUE_W-1:0] out_value,
   output logic [LEN_W-1:0]   out_len,
   output logic               out_valid,
   input  logic               out_ready,
   output logic               error,
   output logic               busy
);

   state_e             state_q, state_d;
   mode_t              mode_q, mode_d;
   logic [VALUE_W-1:0] acc_q, acc_d;
   logic [LEN_W-1:0]   cnt_q, cnt_d;
   logic [VALUE_W-1:0] out_value_q, out_value_d;
   logic [LEN_W-1:0]   out_len_q, out_len_d;
   logic               in_ready_q, in_ready_d;
   logic               out_valid_q, out_valid_d;
   logic               error_q, error_d;
   logic               busy_q, busy_d;

   logic               accept_c, last_slot_c, bad_c, bad_last_c, launch_c;
   logic [6:0]         shift_c, pos_next_c;
   logic [VALUE_W-1:0] merged_c, final_c;

   // Byte classification for the current input byte.
   assign accept_c    = (state_q == ST_ACCUM) && in_valid;
   assign launch_c    = start && ((state_q == ST_IDLE) || (state_q == ST_ERROR));
   assign last_slot_c = (mode_q.vtype == VT_I64) ? (cnt_q == LEN_W'(MAX_BYTES_I64 - 1))
                                                 : (cnt_q == LEN_W'(MAX_BYTES_I32 - 1));
   always_comb begin
      bad_c = in_data[7];
      if (mode_q.vtype == VT_I64) begin
         if (mode_q.is_signed) bad_c = bad_c || !((in_data == 8'h00) || (in_data == 8'h7F));
         else                  bad_c = bad_c || (|in_data[6:1]);
      end else begin
         if (mode_q.is_signed) bad_c = bad_c || !((&in_data[6:3]) || !(|in_data[6:3]));
         else                  bad_c = bad_c || (|in_data[6:4]);
      end
   end
   assign bad_last_c = last_slot_c && bad_c;

   // Accumulate and finalise: shift in 7 payload bits, then sign-extend.
   assign shift_c    = 7'(cnt_q) * 7'd7;
   assign pos_next_c = shift_c + 7'd7;
   assign merged_c   = acc_q | (VALUE_W'(in_data[6:0]) << shift_c);
   always_comb begin
      final_c = merged_c;
      if (mode_q.is_signed && in_data[6] && (pos_next_c < 7'd64))
         final_c = final_c | ({VALUE_W{1'b1}} << pos_next_c[5:0]);
      if (mode_q.vtype != VT_I64)
         final_c[63:32] = mode_q.is_signed ? {32{final_c[31]}} : 32'd0;
   end

   // State register and output flops.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q     <= ST_IDLE;
         mode_q      <= '0;
         acc_q       <= '0;
         cnt_q       <= '0;
         out_value_q <= '0;
         out_len_q   <= '0;
         in_ready_q  <= 1'b0;
         out_valid_q <= 1'b0;
         error_q     <= 1'b0;
         busy_q      <= 1'b0;
      end else begin
         state_q     <= state_d;
         mode_q      <= mode_d;
         acc_q       <= acc_d;
         cnt_q       <= cnt_d;
         out_value_q <= out_value_d;
         out_len_q   <= out_len_d;
         in_ready_q  <= in_ready_d;
         out_valid_q <= out_valid_d;
         error_q     <= error_d;
         busy_q      <= busy_d;
      end
   end

   // Next-state logic.
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         ST_IDLE:  if (start) state_d = ST_ACCUM;
         ST_ACCUM: if (accept_c) begin
                      if (bad_last_c)       state_d = ST_ERROR;
                      else if (!in_data[7]) state_d = ST_DONE;
                   end
         ST_DONE:  if (out_ready) state_d = ST_IDLE;
         ST_ERROR: if (start) state_d = ST_ACCUM;
         default:  state_d = ST_IDLE;
      endcase
   end

   // Datapath and registered status outputs.
   always_comb begin
      mode_d      = mode_q;
      acc_d       = acc_q;
      cnt_d       = cnt_q;
      out_value_d = out_value_q;
      out_len_d   = out_len_q;
      if (launch_c) begin
         mode_d.is_signed = is_signed;
         mode_d.vtype     = width64 ? VT_I64 : VT_I32;
         acc_d            = '0;
         cnt_d            = '0;
      end else if (accept_c) begin
         acc_d = merged_c;
         cnt_d = cnt_q + LEN_W'(1);
         if (!bad_last_c && !in_data[7]) begin
            out_value_d = final_c;
            out_len_d   = cnt_q + LEN_W'(1);
         end
      end
      in_ready_d  = (state_d == ST_ACCUM);
      out_valid_d = (state_d == ST_DONE);
      error_d     = (state_d == ST_ERROR);
      busy_d      = (state_d != ST_IDLE);
   end

   assign in_ready  = in_ready_q;
   assign out_value = out_value_q;
   assign out_len   = out_len_q;
   assign out_valid = out_valid_q;
   assign error     = error_q;
   assign busy      = busy_q;

endmodule

// File: tb/tb_leb128_decoder.sv
// Directed-vector bench for leb128_decoder with hand-computed expectations.
module tb_leb128_decoder;

   logic        clk = 1'b0;
   logic        reset;
   logic        start, is_signed, width64;
   logic [7:0]  in_data;
   logic        in_valid, in_ready;
   logic [63:0] out_value;
   logic [3:0]  out_len;
   logic        out_valid, out_ready, error, busy;

   int          n_checks = 0;
   int          n_errors = 0;
   logic [7:0]  bv [10];
   logic [63:0] hold_val;

   always #5 clk = ~clk;

   leb128_decoder dut (
      .clk(clk), .reset(reset), .start(start), .is_signed(is_signed),
      .width64(width64), .in_data(in_data), .in_valid(in_valid),
      .in_ready(in_ready), .out_value(out_value), .out_len(out_len),
      .out_valid(out_valid), .out_ready(out_ready), .error(error), .busy(busy)
   );

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   task automatic do_start(input logic sgn, input logic w64);
      @(negedge clk);
      start = 1'b1; is_signed = sgn; width64 = w64;
      @(negedge clk);
      start = 1'b0; is_signed = 1'b0; width64 = 1'b0;
   endtask

   // Present one byte and hold it until the edge that accepts it.
   task automatic feed(input logic [7:0] b);
      int n = 0;
      in_data = b; in_valid = 1'b1;
      while (!in_ready && n < 20) begin
         @(negedge clk);
         n++;
      end
      if (n == 20) chk("in_ready_timeout", 64'(in_ready), 64'd1);
      @(negedge clk);
      in_valid = 1'b0;
   endtask

   task automatic decode(input string tag, input logic sgn, input logic w64, input int n,
                         input logic [63:0] exp_val, input logic [3:0] exp_len);
      do_start(sgn, w64);
      for (int i = 0; i < n; i++) begin
         if (i == n - 1) chk({tag, "_valid_pre"}, 64'(out_valid), 64'd0);
         feed(bv[i]);
      end
      chk({tag, "_valid"}, 64'(out_valid), 64'd1);
      chk({tag, "_value"}, out_value, exp_val);
      chk({tag, "_len"}, 64'(out_len), 64'(exp_len));
      chk({tag, "_err"}, 64'(error), 64'd0);
      out_ready = 1'b1;
      @(negedge clk);
      out_ready = 1'b0;
      chk({tag, "_idle"}, 64'(busy), 64'd0);
   endtask

   // Feed n-1 good bytes, then a final byte expected to trip the length check.
   task automatic decode_err(input string tag, input logic sgn, input logic w64, input int n);
      do_start(sgn, w64);
      for (int i = 0; i < n; i++) feed(bv[i]);
      chk({tag, "_error"}, 64'(error), 64'd1);
      chk({tag, "_valid"}, 64'(out_valid), 64'd0);
      chk({tag, "_ready"}, 64'(in_ready), 64'd0);
      chk({tag, "_busy"}, 64'(busy), 64'd1);
   endtask

   initial begin
      reset = 1'b0; start = 1'b0; is_signed = 1'b0; width64 = 1'b0;
      in_data = 8'h00; in_valid = 1'b0; out_ready = 1'b0;
      #1;
      chk("rst_in_ready", 64'(in_ready), 64'd0);
      chk("rst_out_valid", 64'(out_valid), 64'd0);
      chk("rst_error", 64'(error), 64'd0);
      chk("rst_busy", 64'(busy), 64'd0);
      chk("rst_value", out_value, 64'd0);
      chk("rst_len", 64'(out_len), 64'd0);
      repeat (2) @(negedge clk);
      reset = 1'b1;

      // Nothing is consumed in IDLE.
      in_valid = 1'b1; in_data = 8'h05;
      @(negedge clk);
      chk("idle_in_ready", 64'(in_ready), 64'd0);
      in_valid = 1'b0;

      bv = '{8'hE5, 8'h8E, 8'h26, 0, 0, 0, 0, 0, 0, 0};
      decode("u32_624485", 1'b0, 1'b0, 3, 64'd624485, 4'd3);

      bv = '{8'hC0, 8'hBB, 8'h78, 0, 0, 0, 0, 0, 0, 0};
      decode("s64_m123456", 1'b1, 1'b1, 3, 64'hFFFF_FFFF_FFFE_1DC0, 4'd3);

      bv = '{8'h7F, 0, 0, 0, 0, 0, 0, 0, 0, 0};
      decode("s64_m1", 1'b1, 1'b1, 1, 64'hFFFF_FFFF_FFFF_FFFF, 4'd1);

      bv = '{8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'h0F, 0, 0, 0, 0, 0};
      decode("u32_max", 1'b0, 1'b0, 5, 64'h0000_0000_FFFF_FFFF, 4'd5);

      bv = '{8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'h7F, 0, 0, 0, 0, 0};
      decode("s32_m1", 1'b1, 1'b0, 5, 64'hFFFF_FFFF_FFFF_FFFF, 4'd5);

      bv = '{8'h80, 8'h80, 8'h80, 8'h80, 8'h78, 0, 0, 0, 0, 0};
      decode("s32_min", 1'b1, 1'b0, 5, 64'hFFFF_FFFF_8000_0000, 4'd5);

      bv = '{8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'h01};
      decode("u64_max", 1'b0, 1'b1, 10, 64'hFFFF_FFFF_FFFF_FFFF, 4'd10);

      bv = '{8'h80, 8'h80, 8'h80, 8'h80, 8'h80, 8'h80, 8'h80, 8'h80, 8'h80, 8'h7F};
      decode("s64_min", 1'b1, 1'b1, 10, 64'h8000_0000_0000_0000, 4'd10);

      bv = '{8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'h1F, 0, 0, 0, 0, 0};
      decode_err("u32_ovf", 1'b0, 1'b0, 5);
      repeat (2) @(negedge clk);
      chk("u32_ovf_valid_late", 64'(out_valid), 64'd0);

      bv = '{8'h80, 8'h80, 8'h80, 8'h80, 8'h80, 0, 0, 0, 0, 0};
      decode_err("u32_six", 1'b0, 1'b0, 5);
      in_data = 8'h00; in_valid = 1'b1;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         chk("u32_six_no_take", 64'(in_ready), 64'd0);
      end
      in_valid = 1'b0;
      chk("u32_six_err_hold", 64'(error), 64'd1);

      bv = '{8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'h02};
      decode_err("u64_ovf", 1'b0, 1'b1, 10);

      bv = '{8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'h3F, 0, 0, 0, 0, 0};
      decode_err("s32_ovf", 1'b1, 1'b0, 5);

      // Recover from ERROR with a fresh start.
      bv = '{8'h2A, 0, 0, 0, 0, 0, 0, 0, 0, 0};
      decode("recover", 1'b0, 1'b0, 1, 64'd42, 4'd1);

      // Backpressure in DONE; start is ignored there.
      do_start(1'b0, 1'b1);
      feed(8'hAC); feed(8'h02);
      hold_val = 64'd300;
      for (int i = 0; i < 3; i++) begin
         start = 1'b1;
         @(negedge clk);
         chk("bp_valid", 64'(out_valid), 64'd1);
         chk("bp_value", out_value, hold_val);
         chk("bp_len", 64'(out_len), 64'd2);
         chk("bp_in_ready", 64'(in_ready), 64'd0);
      end
      start = 1'b0;
      out_ready = 1'b1;
      @(negedge clk);
      out_ready = 1'b0;
      chk("bp_idle_busy", 64'(busy), 64'd0);
      chk("bp_idle_valid", 64'(out_valid), 64'd0);

      // Reset mid-decode discards the partial value.
      do_start(1'b0, 1'b0);
      feed(8'hFF); feed(8'hFF);
      reset = 1'b0;
      #1;
      chk("mid_rst_busy", 64'(busy), 64'd0);
      chk("mid_rst_ready", 64'(in_ready), 64'd0);
      chk("mid_rst_len", 64'(out_len), 64'd0);
      @(negedge clk);
      reset = 1'b1;
      bv = '{8'h05, 0, 0, 0, 0, 0, 0, 0, 0, 0};
      decode("after_rst", 1'b0, 1'b0, 1, 64'd5, 4'd1);

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog got=timeout exp=finish");
      $fatal(1, "watchdog");
   end

endmodule
